irq_timer: RTL and testbench

Memory-mapped countdown timer that generates the interrupt request consumed by the control unit's `irq` input. It sits on the CPU data bus as a responder to the control unit's `rd`/`wr` strobes. It exposes four word registers (control, reload, count, status) and raises a level-sensitive interrupt when the count expires, either once or periodically.

---
 rtl/timer_pkg.sv | 41 ++++
 rtl/timer_prescaler.sv | 38 +++
 rtl/irq_timer.sv | 127 ++++++++++++
 tb/tb_irq_timer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Purpose: shared types and constants for the memory-mapped interrupt timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_pkg;

  // Width of the prescale field held in CTRL.
  localparam int PRESCALE_W = 8;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_LOAD   = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } timer_reg_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

  // CTRL register image, bit-for-bit as it appears on the bus (bits 15:0).
  typedef struct packed {
    logic [PRESCALE_W-1:0] prescale;
    logic [4:0]            rsvd;
    logic                  periodic;
    logic                  irq_en;
    logic                  enable;
  } timer_ctrl_t;

  localparam int CTRL_W             = $bits(timer_ctrl_t);
  localparam int STATUS_PENDING_BIT = 0;

  // Reserved CTRL bits are never stored, so they always read back as 0.
  function automatic timer_ctrl_t decode_ctrl(input logic [CTRL_W-1:0] raw);
    timer_ctrl_t c;
    c      = timer_ctrl_t'(raw);
    c.rsvd = '0;
    return c;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Purpose: divides the clock by (prescale+1), emitting a one-cycle tick.
// Latency: tick is combinational from the registered divider count.
// Backpressure: none; free-running while enabled.
// Ports: clk, rst (async active-low), enable, clear (restart divider),
//        prescale (divide-minus-one), tick (1-cycle pulse).
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int WIDTH = PRESCALE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] prescale,
  output logic             tick
);

  logic [WIDTH-1:0] pre_cnt_q, pre_cnt_d;

  always_comb begin
    tick      = enable && !clear && (pre_cnt_q == prescale);
    pre_cnt_d = pre_cnt_q + WIDTH'(1);
    // Held at 0 while disabled so a later enable starts a full interval.
    if (!enable || clear || tick) begin
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/irq_timer.sv
// Purpose: memory-mapped countdown timer raising a level interrupt on expiry.
// Latency: reads combinational; writes land on the edge ending the wr cycle.
// Backpressure: none; bus responder always accepts rd/wr when en is high.
// Ports: clk, rst (async active-low), en/rd/wr/addr/data_in bus inputs,
//        data_out (0 unless en && rd), irq (pending & irq_en).
// PRESCALE_WIDTH must not exceed the CTRL prescale field width.
module irq_timer
  import timer_pkg::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int PRESCALE_WIDTH = PRESCALE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [1:0]           addr,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 irq
);

  timer_state_e         state_q, state_d;
  timer_ctrl_t          ctrl_q, ctrl_d;
  logic [WORD_SIZE-1:0] load_q, load_d;
  logic [WORD_SIZE-1:0] count_q, count_d;
  logic                 pending_q, pending_d;

  timer_reg_e  reg_sel;
  timer_ctrl_t wr_fields;
  logic        wr_ctrl, wr_load, wr_count, wr_status;
  logic        tick, tick_eff, expire, pre_clear;

  always_comb begin
    reg_sel   = timer_reg_e'(addr);
    wr_fields = decode_ctrl(data_in[CTRL_W-1:0]);
    wr_ctrl   = en && wr && (reg_sel == REG_CTRL);
    wr_load   = en && wr && (reg_sel == REG_LOAD);
    wr_count  = en && wr && (reg_sel == REG_COUNT);
    wr_status = en && wr && (reg_sel == REG_STATUS);
    pre_clear = wr_ctrl && wr_fields.enable && (state_q == ST_IDLE);
  end

  timer_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .enable   (state_q == ST_RUN),
    .clear    (pre_clear),
    .prescale (ctrl_q.prescale[PRESCALE_WIDTH-1:0]),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    pending_d = pending_q;

    // A software COUNT write or a disabling CTRL write swallows the tick.
    tick_eff = tick && !wr_count && !(wr_ctrl && !wr_fields.enable);
    expire   = tick_eff && (count_q == '0);

    if (tick_eff) begin
      if (!expire) begin
        count_d = count_q - WORD_SIZE'(1);
      end else if (ctrl_q.periodic) begin
        count_d = load_q;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // Clear first so a same-edge expiry keeps pending set.
    if (wr_status && data_in[STATUS_PENDING_BIT]) pending_d = 1'b0;
    if (expire) pending_d = 1'b1;

    if (wr_load)  load_d  = data_in;
    if (wr_count) count_d = data_in;

    if (wr_ctrl) begin
      ctrl_d = wr_fields;
      if (!wr_fields.enable) begin
        state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
        state_d = ST_RUN;
        count_d = load_q;
      end
    end

    // The visible enable bit is the run state itself.
    ctrl_d.enable = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    data_out = '0;
    if (en && rd) begin
      case (reg_sel)
        REG_CTRL:   data_out = WORD_SIZE'(ctrl_q);
        REG_LOAD:   data_out = load_q;
        REG_COUNT:  data_out = count_q;
        REG_STATUS: data_out[STATUS_PENDING_BIT] = pending_q;
        default:    data_out = '0;
      endcase
    end
  end

  assign irq = pending_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_irq_timer.sv
// Purpose: self-checking bench for irq_timer (directed scenarios + random).
// Latency: n/a.
// Backpressure: n/a.
module tb_irq_timer;

  localparam logic [1:0] A_CTRL = 2'd0, A_LOAD = 2'd1, A_COUNT = 2'd2, A_STATUS = 2'd3;

  logic        clk = 1'b0;
  logic        rst, en, rd, wr;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  irq_timer #(.WORD_SIZE(32), .PRESCALE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .rd(rd), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register state advanced once per clock.
  bit          m_en, m_irq_en, m_per, m_pend;
  int unsigned m_presc, m_pre;
  logic [31:0] m_load, m_count;

  function automatic void model_reset();
    m_en = 0; m_irq_en = 0; m_per = 0; m_pend = 0;
    m_presc = 0; m_pre = 0; m_load = 0; m_count = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      A_CTRL: begin
        r[0] = m_en; r[1] = m_irq_en; r[2] = m_per; r[15:8] = m_presc[7:0];
      end
      A_LOAD:  r = m_load;
      A_COUNT: r = m_count;
      default: r[0] = m_pend;
    endcase
    return r;
  endfunction

  function automatic void model_step(input bit e, input bit w, input logic [1:0] a,
                                     input logic [31:0] d);
    bit          cw, lw, kw, sw, tk, tk_use;
    bit          n_en, n_pend;
    logic [31:0] n_count;
    int unsigned n_pre;
    cw = e && w && a == A_CTRL;
    lw = e && w && a == A_LOAD;
    kw = e && w && a == A_COUNT;
    sw = e && w && a == A_STATUS;
    tk = m_en && (m_pre == m_presc);
    n_pre   = (m_en && !tk) ? (m_pre + 1) % 256 : 0;
    n_en    = m_en;
    n_pend  = m_pend;
    n_count = m_count;
    tk_use  = tk && !kw && !(cw && !d[0]);
    if (sw && d[0]) n_pend = 0;
    if (tk_use) begin
      if (m_count != 0) n_count = m_count - 1;
      else begin
        n_pend = 1;
        if (m_per) n_count = m_load;
        else n_en = 0;
      end
    end
    if (kw) n_count = d;
    if (cw) begin
      m_irq_en = d[1];
      m_per    = d[2];
      m_presc  = d[15:8];
      if (d[0] && !m_en) begin
        n_en = 1; n_count = m_load; n_pre = 0;
      end else if (!d[0]) begin
        n_en = 0;
      end
    end
    if (lw) m_load = d;
    m_en = n_en; m_pend = n_pend; m_count = n_count; m_pre = n_pre;
  endfunction

  // One bus cycle: drive after the falling edge, sample read data mid-cycle,
  // let the rising edge commit, return at the next falling edge.
  task automatic bus_cycle(input bit e, input bit r, input bit w, input logic [1:0] a,
                           input logic [31:0] d, output logic [31:0] q);
    en = e; rd = r; wr = w; addr = a; data_in = d;
    #1 q = data_out;
    @(posedge clk);
    model_step(e, w, a, d);
    @(negedge clk);
    en = 0; rd = 0; wr = 0;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus_cycle(1, 0, 1, a, d, q);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] q);
    bus_cycle(1, 1, 0, a, 32'd0, q);
  endtask

  task automatic idle();
    logic [31:0] q;
    bus_cycle(0, 0, 0, A_CTRL, 32'd0, q);
  endtask

  task automatic quiesce();
    write_reg(A_CTRL, 32'd0);
    write_reg(A_STATUS, 32'd1);
  endtask

  task automatic test_reset();
    logic [31:0] q;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    en = 1; rd = 1;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      n_cmp++;
      if (data_out !== 32'd0) begin
        n_err++; $display("FAIL reset_reg%0d: got %0h want 0", a, data_out);
      end
    end
    en = 0; rd = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
    write_reg(A_LOAD, 32'd0);
    write_reg(A_CTRL, 32'h7);
    idle();
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL reset_pre_irq: got %b want 1", irq); end
    #2 rst = 0;
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_async_irq: got %b want 0", irq); end
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), q);
      n_cmp++;
      if (q !== 32'd0) begin n_err++; $display("FAIL reset_after_reg%0d: got %0h want 0", a, q); end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] q;
    int rise, want;
    want = (3 + 1) * (0 + 1);
    rise = -1;
    write_reg(A_LOAD, 32'd3);
    write_reg(A_CTRL, 32'h3);
    for (int c = 1; c <= 12; c++) begin
      idle();
      if (irq === 1'b1 && rise < 0) rise = c;
    end
    n_cmp++;
    if (rise != want) begin n_err++; $display("FAIL oneshot_rise: got cycle %0d want %0d", rise, want); end
    read_reg(A_CTRL, q);
    n_cmp++;
    if (q !== 32'h2) begin n_err++; $display("FAIL oneshot_ctrl: got %0h want 2", q); end
    read_reg(A_COUNT, q);
    n_cmp++;
    if (q !== 32'd0) begin n_err++; $display("FAIL oneshot_count: got %0h want 0", q); end
    quiesce();
  endtask

  task automatic test_periodic();
    int  per;
    bit  exp_irq;
    per = (1 + 1) * (2 + 1);
    write_reg(A_LOAD, 32'd1);
    write_reg(A_CTRL, 32'h207);
    for (int c = 1; c <= 2 * per; c++) begin
      if (c == per + 1) write_reg(A_STATUS, 32'd1);
      else idle();
      exp_irq = (c == per) || (c >= 2 * per);
      n_cmp++;
      if (irq !== exp_irq) begin
        n_err++; $display("FAIL periodic_irq c=%0d: got %b want %b", c, irq, exp_irq);
      end
    end
    quiesce();
  endtask

  task automatic test_collision();
    write_reg(A_LOAD, 32'd0);
    write_reg(A_CTRL, 32'h307);
    repeat (3) idle();
    write_reg(A_STATUS, 32'd1);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL collision_set_wins: got %b want 1", irq); end
    write_reg(A_STATUS, 32'd1);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL collision_clear: got %b want 0", irq); end
    quiesce();
    // LOAD 0, prescale 0, periodic: expiry on every edge outruns each clear.
    write_reg(A_CTRL, 32'h7);
    for (int c = 1; c <= 4; c++) begin
      write_reg(A_STATUS, 32'd1);
      n_cmp++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL every_tick c=%0d: got %b want 1", c, irq); end
    end
    quiesce();
  endtask

  task automatic test_override();
    logic [31:0] q;
    write_reg(A_LOAD, 32'd0);
    write_reg(A_CTRL, 32'h7);
    write_reg(A_COUNT, 32'd10);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL override_no_expiry: got %b want 0", irq); end
    read_reg(A_COUNT, q);
    n_cmp++;
    if (q !== 32'd10) begin n_err++; $display("FAIL override_count: got %0d want 10", q); end
    read_reg(A_COUNT, q);
    n_cmp++;
    if (q !== 32'd9) begin n_err++; $display("FAIL override_decrement: got %0d want 9", q); end
    quiesce();
  endtask

  task automatic test_masking();
    logic [31:0] q;
    bit hi_seen;
    hi_seen = 0;
    write_reg(A_LOAD, 32'd2);
    write_reg(A_CTRL, 32'h1);
    for (int c = 1; c <= 5; c++) begin
      idle();
      if (irq !== 1'b0) hi_seen = 1;
    end
    n_cmp++;
    if (hi_seen) begin n_err++; $display("FAIL mask_irq_low: got 1 want 0"); end
    read_reg(A_STATUS, q);
    n_cmp++;
    if (q !== 32'd1) begin n_err++; $display("FAIL mask_pending: got %0h want 1", q); end
    write_reg(A_CTRL, 32'h2);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL mask_unmask: got %b want 1", irq); end
    write_reg(A_STATUS, 32'd1);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL mask_clear: got %b want 0", irq); end
    quiesce();
  endtask

  task automatic test_back_to_back();
    logic [31:0] q;
    write_reg(A_LOAD, 32'd5);
    bus_cycle(1, 1, 1, A_LOAD, 32'd9, q);
    n_cmp++;
    if (q !== 32'd5) begin n_err++; $display("FAIL rdwr_old_value: got %0d want 5", q); end
    bus_cycle(0, 1, 1, A_LOAD, 32'd77, q);
    n_cmp++;
    if (q !== 32'd0) begin n_err++; $display("FAIL cs_low_read: got %0d want 0", q); end
    read_reg(A_LOAD, q);
    n_cmp++;
    if (q !== 32'd9) begin n_err++; $display("FAIL rdwr_new_value: got %0d want 9", q); end
  endtask

  task automatic test_random();
    logic [31:0] q, d, exp_q;
    logic [1:0]  a;
    bit          e, r, w;
    for (int i = 0; i < 800; i++) begin
      e = ($urandom_range(0, 7) != 0);
      r = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 2) == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == A_CTRL) d[15:8] = 8'($urandom_range(0, 3));
      else if (a != A_STATUS) d = $urandom_range(0, 6);
      exp_q = (e && r) ? model_read(a) : 32'd0;
      bus_cycle(e, r, w, a, d, q);
      n_cmp++;
      if (q !== exp_q) begin
        n_err++; $display("FAIL rand_read i=%0d a=%0d: got %0h want %0h", i, a, q, exp_q);
      end
      n_cmp++;
      if (irq !== (m_pend && m_irq_en)) begin
        n_err++; $display("FAIL rand_irq i=%0d: got %b want %b", i, irq, m_pend && m_irq_en);
      end
    end
  endtask

  initial begin
    rst = 0; en = 0; rd = 0; wr = 0; addr = 2'd0; data_in = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_oneshot();
    test_periodic();
    test_collision();
    test_override();
    test_masking();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
